// File: rtl/to_ascii_radix_if.sv
// Request/response bundle for the number-to-ASCII converter.
interface to_ascii_radix_if #(
  parameter int IN_WIDTH     = 64,
  parameter int OUTPUT_WIDTH = 24
);
  logic [IN_WIDTH-1:0]       VALUE;
  logic [1:0]                MODE;
  logic [7:0]                DIGITS_OUT;
  logic                      NOSEP;
  logic                      START;
  logic [OUTPUT_WIDTH*8-1:0] RESULT;
  logic                      IDLE;
  logic                      DONE;

  modport master (output VALUE, MODE, DIGITS_OUT, NOSEP, START,
                  input  RESULT, IDLE, DONE);
  modport slave  (input  VALUE, MODE, DIGITS_OUT, NOSEP, START,
                  output RESULT, IDLE, DONE);
endinterface

// File: rtl/to_ascii_radix.sv
// Serial number-to-ASCII converter: hex/binary one digit per cycle, decimal via
// bit-serial restoring division by 10. Output is right-justified, LS digit at
// the rightmost character, optional group separators.
module to_ascii_radix #(
  parameter int IN_WIDTH     = 64,
  parameter int OUTPUT_WIDTH = 24
) (
  input  logic            CLK,
  input  logic            RESETN,
  to_ascii_radix_if.slave bus
);

  // Decimal digit count of the largest IN_WIDTH-bit value.
  function automatic int dec_digits(input int w);
    logic [63:0] v;
    int          d;
    v = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    d = 0;
    for (int i = 0; i < 64; i++)
      if (v != 64'd0) begin
        v = v / 64'd10;
        d++;
      end
    return d;
  endfunction

  localparam int MAXD_HEX = (IN_WIDTH + 3) / 4;
  localparam int MAXD_BIN = IN_WIDTH;
  localparam int MAXD_DEC = dec_digits(IN_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_EMIT} state_t;
  typedef enum logic [1:0] {R_HEX, R_DEC, R_BIN} radix_t;

  state_t              state_q;
  radix_t              radix_q;
  logic                nosep_q;
  logic [IN_WIDTH-1:0] val_q;     // working value; holds the quotient during S_DIV
  logic [3:0]          rem_q;     // partial remainder of the running division
  logic [7:0]          tgt_q;     // clamped digit target, 0 = minimal
  logic [7:0]          cnt_q;     // digits emitted so far
  logic [3:0]          grp_q;     // digits since the last separator
  logic [7:0]          ptr_q;     // next character position (0 = leftmost)
  logic [6:0]          bit_q;     // division step counter
  logic                done_q;
  logic [7:0]          res_q [OUTPUT_WIDTH];

  radix_t              rad_d;
  logic [7:0]          maxd_d, tgt_d;
  logic [4:0]          tmp_d, tsub_d;
  logic                ge_d;
  logic [3:0]          rem_d, digit_d, grp_sz_d, grp_d;
  logic [IN_WIDTH-1:0] vdiv_d, vemit_d;
  logic [7:0]          ascii_d, sepc_d, cnt_d;
  logic                more_d, sep_d, fin_d;

  // Request decode: radix and digit target clamped to the radix maximum.
  always_comb begin
    rad_d  = R_HEX;
    maxd_d = 8'(MAXD_HEX);
    case (bus.MODE)
      2'd1:    begin rad_d = R_DEC; maxd_d = 8'(MAXD_DEC); end
      2'd2:    begin rad_d = R_BIN; maxd_d = 8'(MAXD_BIN); end
      default: begin rad_d = R_HEX; maxd_d = 8'(MAXD_HEX); end
    endcase
    tgt_d = (bus.DIGITS_OUT > maxd_d) ? maxd_d : bus.DIGITS_OUT;
  end

  // Division step and emit datapath.
  always_comb begin
    tmp_d  = {rem_q, val_q[IN_WIDTH-1]};
    tsub_d = tmp_d - 5'd10;
    ge_d   = (tmp_d >= 5'd10);
    rem_d  = ge_d ? tsub_d[3:0] : tmp_d[3:0];
    vdiv_d = {val_q[IN_WIDTH-2:0], ge_d};

    digit_d  = val_q[3:0];
    vemit_d  = val_q >> 4;
    grp_sz_d = 4'd4;
    sepc_d   = 8'h5F;
    case (radix_q)
      R_BIN: begin
        digit_d  = {3'b000, val_q[0]};
        vemit_d  = val_q >> 1;
        grp_sz_d = 4'd8;
      end
      R_DEC: begin
        digit_d  = rem_q;
        vemit_d  = val_q;
        grp_sz_d = 4'd3;
        sepc_d   = 8'h2C;
      end
      default: ;
    endcase

    ascii_d = (digit_d < 4'd10) ? (8'h30 + {4'h0, digit_d}) : (8'h57 + {4'h0, digit_d});
    cnt_d   = cnt_q + 8'd1;
    grp_d   = grp_q + 4'd1;
    more_d  = (tgt_q != 8'd0) ? (cnt_d < tgt_q) : (vemit_d != '0);
    sep_d   = !nosep_q && more_d && (grp_d == grp_sz_d) && (ptr_q >= 8'd2);
    fin_d   = !more_d || (ptr_q == 8'd0);
  end

  // Control FSM and result buffer.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q <= S_IDLE;
      radix_q <= R_HEX;
      nosep_q <= 1'b0;
      val_q   <= '0;
      rem_q   <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      grp_q   <= '0;
      ptr_q   <= '0;
      bit_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < OUTPUT_WIDTH; i++) res_q[i] <= 8'h00;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (bus.START) begin
          val_q   <= bus.VALUE;
          radix_q <= rad_d;
          nosep_q <= bus.NOSEP;
          tgt_q   <= tgt_d;
          cnt_q   <= '0;
          grp_q   <= '0;
          ptr_q   <= 8'(OUTPUT_WIDTH - 1);
          rem_q   <= '0;
          bit_q   <= '0;
          for (int i = 0; i < OUTPUT_WIDTH; i++) res_q[i] <= 8'h00;
          state_q <= (rad_d == R_DEC) ? S_DIV : S_EMIT;
        end
        S_DIV: begin
          rem_q <= rem_d;
          val_q <= vdiv_d;
          bit_q <= bit_q + 7'd1;
          if (bit_q == 7'(IN_WIDTH - 1)) state_q <= S_EMIT;
        end
        S_EMIT: begin
          for (int i = 0; i < OUTPUT_WIDTH; i++) begin
            if (8'(i) == ptr_q)                        res_q[i] <= ascii_d;
            else if (sep_d && (8'(i) == ptr_q - 8'd1)) res_q[i] <= sepc_d;
          end
          val_q <= vemit_d;
          rem_q <= '0;
          bit_q <= '0;
          cnt_q <= cnt_d;
          grp_q <= sep_d ? 4'd0 : grp_d;
          ptr_q <= ptr_q - (sep_d ? 8'd2 : 8'd1);
          if (fin_d) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end else begin
            state_q <= (radix_q == R_DEC) ? S_DIV : S_EMIT;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Character 0 is leftmost, mapped to the MSBs.
  for (genvar g = 0; g < OUTPUT_WIDTH; g++) begin : g_res
    assign bus.RESULT[(OUTPUT_WIDTH-1-g)*8 +: 8] = res_q[g];
  end

  assign bus.IDLE = (state_q == S_IDLE) && !bus.START;
  assign bus.DONE = done_q;

endmodule

// File: tb/tb_to_ascii_radix.sv
// Directed bench: three converters (24/19/4 character buffers) share stimulus;
// each vector checks one of them against hand-computed strings and latencies.
module tb_to_ascii_radix;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [63:0] value = '0;
  logic [1:0]  mode = '0;
  logic [7:0]  dig = '0;
  logic        nosep = 1'b0;
  logic        start = 1'b0;
  int          n_vec = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  to_ascii_radix_if #(.IN_WIDTH(64), .OUTPUT_WIDTH(24)) i24();
  to_ascii_radix_if #(.IN_WIDTH(64), .OUTPUT_WIDTH(19)) i19();
  to_ascii_radix_if #(.IN_WIDTH(64), .OUTPUT_WIDTH(4))  i4();

  assign i24.VALUE = value; assign i24.MODE = mode; assign i24.DIGITS_OUT = dig;
  assign i24.NOSEP = nosep; assign i24.START = start;
  assign i19.VALUE = value; assign i19.MODE = mode; assign i19.DIGITS_OUT = dig;
  assign i19.NOSEP = nosep; assign i19.START = start;
  assign i4.VALUE  = value; assign i4.MODE  = mode; assign i4.DIGITS_OUT  = dig;
  assign i4.NOSEP  = nosep; assign i4.START  = start;

  to_ascii_radix #(.IN_WIDTH(64), .OUTPUT_WIDTH(24)) u24 (.CLK(clk), .RESETN(resetn), .bus(i24));
  to_ascii_radix #(.IN_WIDTH(64), .OUTPUT_WIDTH(19)) u19 (.CLK(clk), .RESETN(resetn), .bus(i19));
  to_ascii_radix #(.IN_WIDTH(64), .OUTPUT_WIDTH(4))  u4  (.CLK(clk), .RESETN(resetn), .bus(i4));

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [191:0] res_of(input int sel);
    if (sel == 19) return {40'h0, i19.RESULT};
    if (sel == 4)  return {160'h0, i4.RESULT};
    return i24.RESULT;
  endfunction

  function automatic logic done_of(input int sel);
    if (sel == 19) return i19.DONE;
    if (sel == 4)  return i4.DONE;
    return i24.DONE;
  endfunction

  // Present a request and hold START across one edge (the acceptance edge).
  task automatic go(input logic [63:0] v, input logic [1:0] m, input logic [7:0] d, input logic ns);
    value = v; mode = m; dig = d; nosep = ns; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count edges after acceptance until DONE is seen.
  task automatic wait_done(input int sel, output int lat);
    lat = 0;
    while (lat < 3000) begin
      @(posedge clk); #1;
      lat++;
      if (done_of(sel)) break;
    end
  endtask

  task automatic settle();
    int n = 0;
    while (!(i24.IDLE && i19.IDLE && i4.IDLE) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 3000) chk("settle_timeout", 192'(n), 192'(0));
  endtask

  task automatic conv(input string tag, input int sel, input logic [63:0] v, input logic [1:0] m,
                      input logic [7:0] d, input logic ns, input logic [191:0] exp, input int exp_lat);
    int lat;
    logic [191:0] r;
    go(v, m, d, ns);
    wait_done(sel, lat);
    r = res_of(sel);
    chk({tag, "_res"}, r, exp);
    chk({tag, "_lat"}, 192'(lat), 192'(exp_lat));
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 192'(done_of(sel)), 192'(0));
    chk({tag, "_hold"}, res_of(sel), exp);
    settle();
  endtask

  initial begin
    int lat;
    int ndone;
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_res", i24.RESULT, 192'h0);
    chk("rst_done", 192'(i24.DONE), 192'(0));
    chk("rst_idle", 192'(i24.IDLE), 192'(1));
    start = 1'b1; #1;
    chk("rst_idle_start", 192'(i24.IDLE), 192'(0));
    start = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    conv("hex19",    19, 64'h0123456789ABCDEF, 2'd0, 8'd16, 1'b0, "0123_4567_89ab_cdef", 16);
    conv("dec1234567", 24, 64'd1234567, 2'd1, 8'd0, 1'b0, "1,234,567", 455);
    conv("bin8",     24, 64'hA5, 2'd2, 8'd8,  1'b1, "10100101", 8);
    conv("bin16sep", 24, 64'hA5, 2'd2, 8'd16, 1'b0, "00000000_10100101", 16);
    conv("zero_hex", 24, 64'h0, 2'd0, 8'd0, 1'b0, "0", 1);
    conv("zero_dec", 24, 64'h0, 2'd1, 8'd0, 1'b0, "0", 65);
    conv("zero_bin", 24, 64'h0, 2'd2, 8'd0, 1'b0, "0", 1);
    conv("zero_hex3", 24, 64'h0, 2'd3, 8'd0, 1'b0, "0", 1);
    conv("trunc4",   4,  64'h89ABCDEF, 2'd0, 8'd8, 1'b0, "cdef", 4);
    conv("hexmin",   24, 64'hDEADBEEF, 2'd3, 8'd0, 1'b0, "dead_beef", 8);
    conv("hexclamp", 24, 64'h1, 2'd0, 8'd40, 1'b1, "0000000000000001", 16);
    conv("declz",    24, 64'd42, 2'd1, 8'd5, 1'b0, "00,042", 325);
    conv("dectrunc4", 4, 64'd1234567, 2'd1, 8'd0, 1'b0, "4567", 260);
    conv("decmax",   24, {64{1'b1}}, 2'd1, 8'd0, 1'b1, "18446744073709551615", 1300);

    // back-to-back: START held in the DONE cycle
    go(64'hAB, 2'd0, 8'd0, 1'b1);
    wait_done(24, lat);
    chk("b2b_first", i24.RESULT, "ab");
    go(64'h3C, 2'd0, 8'd0, 1'b1);
    chk("b2b_clear", i24.RESULT, 192'h0);
    wait_done(24, lat);
    chk("b2b_res", i24.RESULT, "3c");
    chk("b2b_lat", 192'(lat), 192'(2));
    settle();

    // START during a busy decimal conversion is ignored
    go(64'd987, 2'd1, 8'd0, 1'b0);
    repeat (30) @(posedge clk);
    #1;
    value = 64'hFF; mode = 2'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(24, lat);
    chk("busy_res", i24.RESULT, "987");
    chk("busy_lat", 192'(lat), 192'(164));
    settle();

    // reset mid-decimal conversion
    go(64'd1234567, 2'd1, 8'd0, 1'b0);
    repeat (100) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("midrst_res", i24.RESULT, 192'h0);
    chk("midrst_done", 192'(i24.DONE), 192'(0));
    chk("midrst_idle", 192'(i24.IDLE), 192'(1));
    resetn = 1'b1;
    ndone = 0;
    repeat (600) begin
      @(posedge clk); #1;
      if (i24.DONE) ndone++;
    end
    chk("midrst_nodone", 192'(ndone), 192'(0));
    chk("midrst_stay0", i24.RESULT, 192'h0);
    conv("postrst", 24, 64'd1234567, 2'd1, 8'd0, 1'b0, "1,234,567", 455);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
